// File: rtl/fp_seq_addsub.sv
// ---------------------------------------------------------------------------
// fp_seq_addsub
//
// Multi-cycle IEEE-754 adder/subtractor used by the FP divider's
// Newton-Raphson loop (48/17 - x, 2 - xD). It takes one operand pair per Load
// pulse and, some cycles later, presents the rounded sum or difference with
// Valid. Rounding is round-to-nearest-even. Subnormal inputs are treated as
// zero, and subnormal results are flushed to a signed zero.
//
// Ports
//   Clk     in   1          clock, rising edge
//   Rst_n   in   1          asynchronous active-low reset
//   A       in   PRECISION  operand A, sampled on the Load edge
//   B       in   PRECISION  operand B, sampled on the Load edge
//   Op      in   1          0: A+B, 1: A-B, sampled on the Load edge
//   Load    in   1          start pulse; also aborts any operation in flight
//   Result  out  PRECISION  registered result, held until the next Load
//   Valid   out  1          result ready, masked in any cycle where Load=1
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fp_seq_addsub #(
   parameter int PRECISION = 32
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [PRECISION-1:0] A,
   input  logic [PRECISION-1:0] B,
   input  logic                 Op,
   input  logic                 Load,
   output logic [PRECISION-1:0] Result,
   output logic                 Valid
);

   localparam int P = PRECISION;
   localparam int E = (PRECISION == 64) ? 11 : 8;
   localparam int M = PRECISION - E - 1;
   // Working mantissa layout: hidden bit, M fraction bits, then guard, round
   // and sticky bits.
   localparam int W = M + 4;
   localparam logic [E-1:0] SHIFT_SAT  = E'(W);
   localparam logic [P-1:0] CANON_NAN  = {1'b0, {(P-1){1'b1}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

   state_t         state_q, state_d;
   logic [P-1:0]   opA_q, opA_d;
   logic [P-1:0]   opB_q, opB_d;
   logic           sign_q, sign_d;
   logic [E:0]     exp_q, exp_d;
   logic [W-1:0]   mant_q, mant_d;
   logic [W-1:0]   yMant_q, yMant_d;
   logic           effSub_q, effSub_d;
   logic [P-1:0]   result_q, result_d;
   logic           valid_q, valid_d;

   // Load-time operand classification
   logic [P-1:0]   effB;
   logic [E-1:0]   expA, expB;
   logic [M-1:0]   fracA, fracB;
   logic           aZero, bZero, aInf, bInf, aNan, bNan;
   logic           loadSpecial;
   logic [P-1:0]   specialResult;

   // Alignment datapath
   logic           swapOps;
   logic           alignSign;
   logic [P-2:0]   xMag, yMag;
   logic [E-1:0]   expDiff, shAmt;
   logic [W-1:0]   xField, yField, yAligned;
   logic [2*W-1:0] yWide;

   // Add, normalise and round datapath
   logic [W:0]     addSum;
   logic [W-1:0]   mantShl;
   logic [E:0]     expDec;
   logic           roundUp;
   logic [M+1:0]   rounded;
   logic [E:0]     expRnd;
   logic [M-1:0]   fracRnd;
   logic [P-1:0]   roundResult;

   // B is folded with Op at load time, so the rest of the datapath only
   // ever sees an addition of two signed magnitudes.
   assign effB  = B ^ {Op, {(P-1){1'b0}}};
   assign expA  = A[P-2:M];
   assign fracA = A[M-1:0];
   assign expB  = effB[P-2:M];
   assign fracB = effB[M-1:0];
   assign aZero = (expA == '0);
   assign bZero = (expB == '0);
   assign aInf  = (expA == '1) && (fracA == '0);
   assign bInf  = (expB == '1) && (fracB == '0);
   assign aNan  = (expA == '1) && (fracA != '0);
   assign bNan  = (expB == '1) && (fracB != '0);

   // Operands whose answer is known without arithmetic finish on the Load
   // edge itself. Priority matters: NaN beats Inf, Inf beats zero.
   always_comb begin
      loadSpecial   = 1'b1;
      specialResult = '0;
      if (aNan || bNan || (aInf && bInf && (A[P-1] != effB[P-1]))) begin
         specialResult = CANON_NAN;
      end else if (aInf) begin
         specialResult = A;
      end else if (bInf) begin
         specialResult = effB;
      end else if (aZero && bZero) begin
         specialResult = '0;
      end else if (aZero) begin
         specialResult = effB;
      end else if (bZero) begin
         specialResult = A;
      end else begin
         loadSpecial = 1'b0;
      end
   end

   // X is the larger magnitude operand. Comparing exponent and fraction as
   // one unsigned field gives the magnitude order directly.
   assign swapOps   = opB_q[P-2:0] > opA_q[P-2:0];
   assign xMag      = swapOps ? opB_q[P-2:0] : opA_q[P-2:0];
   assign yMag      = swapOps ? opA_q[P-2:0] : opB_q[P-2:0];
   assign alignSign = swapOps ? opB_q[P-1] : opA_q[P-1];
   assign expDiff   = xMag[P-2:M] - yMag[P-2:M];
   assign shAmt     = (expDiff > SHIFT_SAT) ? SHIFT_SAT : expDiff;
   assign xField    = {1'b1, xMag[M-1:0], 3'b000};
   assign yField    = {1'b1, yMag[M-1:0], 3'b000};
   // The low half of the wide shift collects every bit shifted out of Y,
   // which collapses into the sticky position.
   assign yWide     = {yField, {W{1'b0}}} >> shAmt;
   assign yAligned  = {yWide[2*W-1:W+1], yWide[W] | (|yWide[W-1:0])};

   // Since |X| >= |Y| the subtraction never goes negative.
   assign addSum = effSub_q ? ({1'b0, mant_q} - {1'b0, yMant_q})
                            : ({1'b0, mant_q} + {1'b0, yMant_q});

   assign mantShl = {mant_q[W-2:0], 1'b0};
   assign expDec  = exp_q - 1'b1;

   // Round to nearest, ties to even, on the guard/round/sticky tail. A
   // carry out of the rounded mantissa only happens for all-ones, so the
   // renormalised fraction is simply zero.
   assign roundUp     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
   assign rounded     = {1'b0, mant_q[W-1:3]} + {{(M+1){1'b0}}, roundUp};
   assign expRnd      = exp_q + {{E{1'b0}}, rounded[M+1]};
   assign fracRnd     = rounded[M+1] ? rounded[M:1] : rounded[M-1:0];
   assign roundResult = (expRnd >= {1'b0, {E{1'b1}}})
                        ? {sign_q, {E{1'b1}}, {M{1'b0}}}
                        : {sign_q, expRnd[E-1:0], fracRnd};

   // Next-state logic. The state case runs first and a Load then overrides
   // it, so a new operand pair always wins over whatever was in flight.
   always_comb begin
      state_d  = state_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      yMant_d  = yMant_q;
      effSub_d = effSub_q;
      result_d = result_q;
      valid_d  = valid_q;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         ALIGN: begin
            sign_d   = alignSign;
            exp_d    = {1'b0, xMag[P-2:M]};
            mant_d   = xField;
            yMant_d  = yAligned;
            effSub_d = opA_q[P-1] ^ opB_q[P-1];
            state_d  = ADD;
         end
         ADD: begin
            if (addSum[W]) begin
               mant_d = {addSum[W:2], addSum[1] | addSum[0]};
               exp_d  = exp_q + 1'b1;
            end else begin
               mant_d = addSum[W-1:0];
            end
            state_d = NORM;
         end
         NORM: begin
            // One left shift per cycle; the shift that brings the hidden
            // bit up moves straight on to ROUND.
            if (mant_q == '0) begin
               result_d = '0;
               state_d  = DONE;
            end else if (mant_q[W-1]) begin
               state_d = ROUND;
            end else begin
               mant_d = mantShl;
               exp_d  = expDec;
               if (expDec == '0) begin
                  result_d = {sign_q, {(P-1){1'b0}}};
                  state_d  = DONE;
               end else if (mantShl[W-1]) begin
                  state_d = ROUND;
               end
            end
         end
         ROUND: begin
            result_d = roundResult;
            state_d  = DONE;
         end
         DONE: begin
            valid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (Load) begin
         opA_d   = A;
         opB_d   = effB;
         valid_d = 1'b0;
         if (loadSpecial) begin
            result_d = specialResult;
            state_d  = DONE;
         end else begin
            state_d = ALIGN;
         end
      end
   end

   // State and datapath registers; reset clears everything at once, which
   // also throws away any operation in progress.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         opA_q    <= '0;
         opB_q    <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         yMant_q  <= '0;
         effSub_q <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         yMant_q  <= yMant_d;
         effSub_q <= effSub_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   // The divider samples Valid in the same cycle it drives Load, so a
   // finished result must never show through while a new one is requested.
   assign Result = result_q;
   assign Valid  = valid_q & ~Load;

endmodule

// File: tb/tb_fp_seq_addsub.sv
// ---------------------------------------------------------------------------
// tb_fp_seq_addsub
//
// Self-checking bench for fp_seq_addsub in single precision. It covers
// directed cases with known results and latencies, special operands, abort
// and reset behaviour, and a randomized sweep against an exact-arithmetic
// reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fp_seq_addsub;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic        Op;
   logic        Load;
   logic [31:0] Result;
   logic        Valid;

   int checks   = 0;
   int failures = 0;

   fp_seq_addsub #(.PRECISION(32)) dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .A      (A),
      .B      (B),
      .Op     (Op),
      .Load   (Load),
      .Result (Result),
      .Valid  (Valid)
   );

   // 100 MHz clock
   always #5 Clk = ~Clk;

   // Exact reference: both significands are placed on a common 128-bit
   // integer grid, added exactly, then rounded to 24 bits with RNE. A
   // smaller operand more than 40 binades down is pinned at 40 binades,
   // which keeps it far below a quarter ulp and so cannot change the result.
   function automatic logic [31:0] refAddSub(input logic [31:0] a,
                                             input logic [31:0] bIn,
                                             input logic op);
      logic [31:0]  b;
      logic [7:0]   ea, eb;
      logic [22:0]  fa, fb;
      logic         sa, sb, sign;
      logic [127:0] vA, vB, mag, q, rem, half;
      int           eMax, dA, dB, p, sh, e;
      b  = bIn ^ {op, 31'b0};
      sa = a[31]; ea = a[30:23]; fa = a[22:0];
      sb = b[31]; eb = b[30:23]; fb = b[22:0];
      if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FFFFFFF;
      if (ea == 8'hFF && eb == 8'hFF && sa != sb) return 32'h7FFFFFFF;
      if (ea == 8'hFF) return a;
      if (eb == 8'hFF) return b;
      if (ea == 0 && eb == 0) return 32'h0;
      if (ea == 0) return b;
      if (eb == 0) return a;
      eMax = (ea > eb) ? int'(ea) : int'(eb);
      dA = eMax - int'(ea); if (dA > 40) dA = 40;
      dB = eMax - int'(eb); if (dB > 40) dB = 40;
      vA = {104'b0, 1'b1, fa} << (40 - dA);
      vB = {104'b0, 1'b1, fb} << (40 - dB);
      if (sa == sb) begin
         mag = vA + vB; sign = sa;
      end else if (vA > vB) begin
         mag = vA - vB; sign = sa;
      end else if (vB > vA) begin
         mag = vB - vA; sign = sb;
      end else begin
         return 32'h0;
      end
      p = 127;
      while (!mag[p]) p--;
      e = eMax + p - 63;
      if (e <= 0) return {sign, 31'b0};
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {sign, 8'hFF, 23'b0};
      return {sign, e[7:0], q[22:0]};
   endfunction

   // Random operand biased towards interesting exponent regions
   function automatic logic [31:0] randOperand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[30:23] = 8'h00;
         1: begin
            r[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) r[22:0] = '0;
         end
         2: r[30:23] = 8'(253 + $urandom_range(0, 1));
         3: r[30:23] = 8'($urandom_range(1, 3));
         default: r[30:23] = 8'($urandom_range(100, 154));
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Presents one operand pair with a single-cycle Load, then scrambles the
   // inputs so only the latched values can matter.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic op);
      @(negedge Clk);
      A = a; B = b; Op = op; Load = 1'b1;
      #1;
      checkOutput("validMaskedDuringLoad", {31'b0, Valid}, 32'd0);
      @(posedge Clk);
      #1;
      Load = 1'b0;
      A  = $urandom;
      B  = $urandom;
      Op = 1'($urandom);
   endtask

   task automatic waitValid(input string tag, output int lat);
      lat = 0;
      while (!Valid && lat < 100) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      checkOutput({tag, "_validSeen"}, {31'b0, Valid}, 32'd1);
   endtask

   // expLat < 0 means the latency is not checked for this operation
   task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] expRes, input int expLat);
      int lat;
      applyStimulus(a, b, op);
      waitValid(tag, lat);
      checkOutput({tag, "_result"}, Result, expRes);
      if (expLat >= 0) checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rop;

      Rst_n = 1'b0; Load = 1'b0; A = '0; B = '0; Op = 1'b0;
      #12;
      checkOutput("resetResult", Result, 32'h0);
      checkOutput("resetValid", {31'b0, Valid}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;

      // Directed normal-path cases with their latencies
      runOp("T1_onePlusTwo", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5);
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("T1_heldResult", Result, 32'h40400000);
      checkOutput("T1_heldValid", {31'b0, Valid}, 32'd1);
      runOp("T2_twoMinusOneHalf", 32'h40000000, 32'h3FC00000, 1'b1, 32'h3F000000, 6);
      runOp("T3_cancel", 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 28);

      // Rounding ties
      runOp("T4_tieEven", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, -1);
      runOp("T4_tieOdd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, -1);

      // Specials and boundaries
      runOp("T5_infMinusInf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FFFFFFF, 1);
      runOp("T5_overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, -1);
      runOp("T5_exactZero", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, -1);
      runOp("nanIn", 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FFFFFFF, 1);
      runOp("oneMinusInf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1);
      runOp("zeroMinusOne", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1);
      runOp("piPlusZero", 32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 1);
      runOp("subnormInputs", 32'h00000001, 32'h00000002, 1'b0, 32'h00000000, 1);
      runOp("negZeros", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1);
      runOp("flushNeg", 32'h80800001, 32'h00800000, 1'b0, 32'h80000000, -1);

      // Re-Load while T3 is still normalising: only the new result appears
      applyStimulus(32'h3F800000, 32'h3F7FFFFF, 1'b1);
      repeat (8) @(posedge Clk);
      runOp("T6_reload", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5);

      // Asynchronous reset while in ADD clears the outputs immediately
      applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
      @(posedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      checkOutput("T6_resetMidResult", Result, 32'h0);
      checkOutput("T6_resetMidValid", {31'b0, Valid}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (8) @(posedge Clk);
      #1;
      checkOutput("T6_discardedValid", {31'b0, Valid}, 32'd0);
      checkOutput("T6_discardedResult", Result, 32'h0);

      // Randomized sweep against the reference model
      for (int i = 0; i < 150; i++) begin
         ra  = randOperand();
         rb  = ($urandom_range(0, 2) == 0)
               ? {1'($urandom), ra[30:0] + 31'($urandom_range(0, 64)) - 31'd32}
               : randOperand();
         rop = 1'($urandom);
         runOp("random", ra, rb, rop, refAddSub(ra, rb, rop), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
